// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared types and glyph table for the seven-segment scan controller
//
// Purpose: segment vector type, active-high hex glyph table and the blank
//          segment constant used by the decoder and the scan controller.
// Ports:   none (package).

package sev_seg_pkg;

  // Segment vector, bit0 = a ... bit6 = g, active-high.
  typedef logic [6:0] seg_t;

  // All segments off (active-high sense).
  localparam seg_t SEG_OFF = 7'h00;

  // Standard hex glyphs; b and d are lowercase so they differ from 8 and 0.
  localparam seg_t HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/sev_seg_decoder.sv
// rtl/sev_seg_decoder.sv - registered hex nibble plus decimal point to segment decoder
//
// Purpose: converts the currently scanned nibble and its decimal point into
//          registered segment/DP pin levels; a dark slot drives both inactive.
// Ports:
//   clk       in   core clock
//   reset     in   asynchronous, active-high reset (outputs go inactive)
//   nibble_i  in   4-bit hex value of the scanned digit
//   dp_i      in   decimal point request of the scanned digit
//   lit_i     in   1 = digit lit this slot, 0 = drive everything inactive
//   seg_o     out  segment pins, bit0 = a ... bit6 = g
//   dp_o      out  decimal point pin

import sev_seg_pkg::*;

module sev_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       lit_i,
  output seg_t       seg_o,
  output logic       dp_o
);

  localparam seg_t SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic DP_IDLE  = ACTIVE_LOW;

  seg_t seg_d, seg_q;
  logic dp_d, dp_q;

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    if (lit_i) begin
      seg_d = hex_to_seg(nibble_i);
      dp_d  = dp_i;
    end
    // Pin polarity is applied last so the blank case inverts along with the glyphs.
    if (ACTIVE_LOW) begin
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_IDLE;
      dp_q  <= DP_IDLE;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// rtl/sev_seg_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous loading
//
// Purpose: scans NUM_DIGITS common-anode digits from a staged/shadowed hex
//          word with per-digit DP and enable, leading-zero blanking, PWM
//          brightness and a one-cycle ghosting guard at the start of each slot.
// Ports:
//   clk           in   core clock
//   reset         in   asynchronous, active-high reset
//   digits_i      in   packed hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   dp_i          in   per-digit decimal point request
//   en_mask_i     in   per-digit enable, 0 forces the digit dark
//   brightness_i  in   duty level, 0 = off, all-ones = always on
//   lz_blank_i    in   enable leading-zero blanking
//   load_i        in   single-cycle strobe capturing the inputs above into staging
//   seg_o         out  segment pins, bit0 = a ... bit6 = g
//   dp_o          out  decimal point pin
//   an_o          out  anode selects, one-hot (in pin polarity) when lit
//   frame_done_o  out  one-cycle pulse after every frame boundary

import sev_seg_pkg::*;

module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_CNT    = 50000,
  parameter int BRIGHT_W   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_mask_i,
  input  logic [BRIGHT_W-1:0]     brightness_i,
  input  logic                    lz_blank_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int SLOT_W = $clog2(DIV_CNT);
  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(DIV_CNT - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE   = ACTIVE_LOW ? '1 : '0;

  // Staging (written by load_i) and shadow (what is on the glass).
  logic [4*NUM_DIGITS-1:0] stg_digits_d, stg_digits_q, shd_digits_d, shd_digits_q;
  logic [NUM_DIGITS-1:0]   stg_dp_d, stg_dp_q, shd_dp_d, shd_dp_q;
  logic [NUM_DIGITS-1:0]   stg_en_d, stg_en_q, shd_en_d, shd_en_q;
  logic [BRIGHT_W-1:0]     stg_bright_d, stg_bright_q, shd_bright_d, shd_bright_q;
  logic                    stg_lz_d, stg_lz_q, shd_lz_d, shd_lz_q;
  logic                    pending_d, pending_q;

  logic [SLOT_W-1:0]       slot_d, slot_q;
  logic [DIG_W-1:0]        dig_d, dig_q;
  logic [BRIGHT_W-1:0]     pwm_d, pwm_q;

  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic                    frame_done_d, frame_done_q;

  logic                    slot_last, dig_last, boundary;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic [3:0]              cur_nibble;
  logic                    cur_dp, cur_en, cur_blank;
  logic                    pwm_on, lit;

  assign slot_last = (slot_q == SLOT_LAST);
  assign dig_last  = (dig_q == DIG_LAST);
  assign boundary  = slot_last & dig_last;

  // Staging, pending flag and frame-synchronous commit into the shadow.
  // A load on the boundary edge lands in staging only; the commit on that
  // same edge still copies the previous staging contents.
  always_comb begin
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_en_d     = stg_en_q;
    stg_bright_d = stg_bright_q;
    stg_lz_d     = stg_lz_q;
    shd_digits_d = shd_digits_q;
    shd_dp_d     = shd_dp_q;
    shd_en_d     = shd_en_q;
    shd_bright_d = shd_bright_q;
    shd_lz_d     = shd_lz_q;
    pending_d    = pending_q;

    if (boundary && pending_q) begin
      shd_digits_d = stg_digits_q;
      shd_dp_d     = stg_dp_q;
      shd_en_d     = stg_en_q;
      shd_bright_d = stg_bright_q;
      shd_lz_d     = stg_lz_q;
      pending_d    = 1'b0;
    end
    if (load_i) begin
      stg_digits_d = digits_i;
      stg_dp_d     = dp_i;
      stg_en_d     = en_mask_i;
      stg_bright_d = brightness_i;
      stg_lz_d     = lz_blank_i;
      pending_d    = 1'b1;
    end
  end

  // Scan counters. The PWM phase advances once per frame so every slot of a
  // frame shares one duty decision and a digit never changes state mid-slot.
  always_comb begin
    slot_d = slot_last ? '0 : slot_q + 1'b1;
    dig_d  = dig_q;
    if (slot_last) begin
      dig_d = dig_last ? '0 : dig_q + 1'b1;
    end
    pwm_d = boundary ? pwm_q + 1'b1 : pwm_q;
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (shd_digits_q[4*k +: 4] == 4'h0);
      lz_mask[k] = shd_lz_q & zero_run;
    end
  end

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_q == DIG_W'(k)) begin
        cur_nibble = shd_digits_q[4*k +: 4];
        cur_dp     = shd_dp_q[k];
        cur_en     = shd_en_q[k];
        cur_blank  = lz_mask[k];
      end
    end
  end

  assign pwm_on = (&shd_bright_q) | (pwm_q < shd_bright_q);
  // slot 0 of every digit is kept dark so the previous digit's anode and the
  // next digit's segments never overlap on the pins.
  assign lit    = cur_en & ~cur_blank & pwm_on & (slot_q != '0);

  always_comb begin
    an_d = '0;
    if (lit) begin
      an_d = NUM_DIGITS'(1) << dig_q;
    end
    if (ACTIVE_LOW) begin
      an_d = ~an_d;
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      stg_bright_q <= '1;
      stg_lz_q     <= 1'b0;
      shd_digits_q <= '0;
      shd_dp_q     <= '0;
      shd_en_q     <= '0;
      shd_bright_q <= '1;
      shd_lz_q     <= 1'b0;
      pending_q    <= 1'b0;
      slot_q       <= '0;
      dig_q        <= '0;
      pwm_q        <= '0;
      an_q         <= AN_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      stg_digits_q <= stg_digits_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      stg_bright_q <= stg_bright_d;
      stg_lz_q     <= stg_lz_d;
      shd_digits_q <= shd_digits_d;
      shd_dp_q     <= shd_dp_d;
      shd_en_q     <= shd_en_d;
      shd_bright_q <= shd_bright_d;
      shd_lz_q     <= shd_lz_d;
      pending_q    <= pending_d;
      slot_q       <= slot_d;
      dig_q        <= dig_d;
      pwm_q        <= pwm_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  sev_seg_decoder #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decoder (
    .clk      (clk),
    .reset    (reset),
    .nibble_i (cur_nibble),
    .dp_i     (cur_dp),
    .lit_i    (lit),
    .seg_o    (seg_o),
    .dp_o     (dp_o)
  );

  assign an_o         = an_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb/tb_sev_seg_scan_ctrl.sv - self-checking bench for sev_seg_scan_ctrl against a cycle-index reference model

module tb_sev_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 4;
  localparam int BW    = 2;
  localparam int FRAME = ND * DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [4*ND-1:0] digits_i = '0;
  logic [ND-1:0]   dp_i = '0;
  logic [ND-1:0]   en_mask_i = '0;
  logic [BW-1:0]   brightness_i = '0;
  logic            lz_blank_i = 1'b0;
  logic            load_i = 1'b0;
  logic [6:0]      seg_o;
  logic            dp_o;
  logic [ND-1:0]   an_o;
  logic            frame_done_o;

  int checks = 0;
  int errors = 0;
  int n = 0;

  typedef struct {
    int          edge_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [1:0]  br;
    logic        lz;
  } load_t;

  load_t loads[$];

  sev_seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DIV_CNT    (DIV),
    .BRIGHT_W   (BW),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .en_mask_i    (en_mask_i),
    .brightness_i (brightness_i),
    .lz_blank_i   (lz_blank_i),
    .load_i       (load_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Outputs after edge cyc show scan position cyc-1. The shadow in use is the
  // newest load sampled strictly before the most recent frame boundary edge.
  function automatic void model(input int cyc, output logic [3:0] an,
                                output logic [6:0] seg, output logic dp,
                                output logic fd);
    load_t sh;
    int s, e_commit, slot, dig, pwm;
    logic lit, blank;
    logic [3:0] nib;
    an = 4'hF; seg = 7'h7F; dp = 1'b1; fd = 1'b0;
    if (cyc == 0) return;
    s        = cyc - 1;
    e_commit = (s / FRAME) * FRAME;
    sh.edge_n = 0; sh.digits = '0; sh.dp = '0; sh.en = '0; sh.br = 2'b11; sh.lz = 1'b0;
    foreach (loads[i]) begin
      if (e_commit > 0 && loads[i].edge_n < e_commit) sh = loads[i];
    end
    slot  = s % DIV;
    dig   = (s / DIV) % ND;
    pwm   = (s / FRAME) % 4;
    nib   = sh.digits[4*dig +: 4];
    blank = sh.lz && (dig != 0) && ((sh.digits >> (4*dig)) == 16'h0);
    lit   = sh.en[dig] && (slot != 0) && !blank && (sh.br == 2'b11 || pwm < int'(sh.br));
    fd    = (cyc % FRAME == 0);
    if (lit) begin
      an  = ~(4'b0001 << dig);
      seg = ~GLYPH[nib];
      dp  = ~sh.dp[dig];
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, n, obs, expv);
    end
  endtask

  task automatic check_now();
    logic [3:0] ea;
    logic [6:0] es;
    logic ed, ef;
    model(n, ea, es, ed, ef);
    check("an_o", {12'h0, an_o}, {12'h0, ea});
    check("seg_o", {9'h0, seg_o}, {9'h0, es});
    check("dp_o", {15'h0, dp_o}, {15'h0, ed});
    check("frame_done_o", {15'h0, frame_done_o}, {15'h0, ef});
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] en, input logic [1:0] br, input logic lz);
    load_t l;
    digits_i = d; dp_i = dp; en_mask_i = en; brightness_i = br; lz_blank_i = lz;
    load_i = 1'b1;
    l.edge_n = n + 1; l.digits = d; l.dp = dp; l.en = en; l.br = br; l.lz = lz;
    loads.push_back(l);
    step(1);
    load_i = 1'b0;
  endtask

  // Step until the next edge is a frame boundary edge (bounded).
  task automatic wait_pre_boundary();
    int k;
    k = 0;
    while (((n + 1) % FRAME) != 0 && k < 2 * FRAME) begin
      step(1);
      k++;
    end
    check("pre_boundary_reached", {15'h0, (((n + 1) % FRAME) == 0)}, 16'h1);
  endtask

  initial begin
    // Reset state, then idle: default shadow has every digit disabled.
    step(3);
    reset = 1'b0;
    step(100);

    do_load(16'h12AF, 4'h0, 4'hF, 2'd3, 1'b0);
    step(40);

    do_load(16'h0030, 4'h5, 4'hF, 2'd3, 1'b1);
    step(40);
    do_load(16'h0000, 4'hF, 4'hF, 2'd3, 1'b1);
    step(40);

    // Two loads inside one frame: only the later one may ever be shown.
    step(5);
    do_load(16'h1111, 4'h0, 4'hF, 2'd3, 1'b0);
    step(3);
    do_load(16'h2222, 4'h0, 4'hF, 2'd3, 1'b0);
    step(40);

    // Load sampled on the boundary edge itself waits one more frame.
    wait_pre_boundary();
    do_load(16'h5A5A, 4'hA, 4'hF, 2'd3, 1'b0);
    step(40);

    do_load(16'h8888, 4'h3, 4'hF, 2'd1, 1'b0);
    step(80);
    do_load(16'h9999, 4'hF, 4'hF, 2'd0, 1'b0);
    step(40);

    for (int r = 0; r < 20; r++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
      step($urandom_range(1, 20));
    end
    step(40);

    // Reset mid-frame at digit 2 with a load still pending.
    do_load(16'hCDEF, 4'h1, 4'hF, 2'd3, 1'b0);
    begin
      int k;
      k = 0;
      while (!(((n / DIV) % ND) == 2 && (n % DIV) == 1) && k < 2 * FRAME) begin
        step(1);
        k++;
      end
      check("dig2_reached", {15'h0, (((n / DIV) % ND) == 2)}, 16'h1);
    end
    reset = 1'b1;
    #1;
    loads.delete();
    check_now();
    step(2);
    reset = 1'b0;
    step(40);

    do_load(16'hB00D, 4'h0, 4'hF, 2'd3, 1'b1);
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
